// File: rtl/alu_exec_unit_pkg.sv
// Shared opcode, CCR bit index and FSM state definitions for alu_exec_unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_NOT  = 4'd5,
        OP_INC  = 4'd6,
        OP_DEC  = 4'd7,
        OP_MOV  = 4'd8,
        OP_LDM  = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_SETC = 4'd12,
        OP_CLRC = 4'd13,
        OP_MUL  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the ID/EX stage (master) and alu_exec_unit (slave).
interface alu_exec_unit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    alu_op_e          op;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [WIDTH-1:0] imm;
    logic             flush;
    logic             ccr_load;
    logic [2:0]       ccr_in;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [2:0]       ccr;
    logic             busy;

    modport master (
        output in_valid, op, src, dst, imm, flush, ccr_load, ccr_in,
        input  in_ready, out_valid, result, ccr, busy
    );

    modport slave (
        input  in_valid, op, src, dst, imm, flush, ccr_load, ccr_in,
        output in_ready, out_valid, result, ccr, busy
    );

endinterface

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, done on the last one.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);

    logic               active;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;

    // product presents the accumulator including this cycle's partial product,
    // so the final value is usable on the same edge that done is high
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = active && (cnt == SHW'(WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (active) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result/CCR and valid/ready issue handshake.
// Define ALU_MUL_EN to enable the multi-cycle MUL opcode; otherwise op 14 behaves as NOP.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       ccr_q;
    logic             out_valid_q;
    logic             accept;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] res_c;
    logic [2:0]       ccr_c;
    logic [WIDTH:0]   wide;
    logic             set_zn;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [2:0]       mul_ccr;

    assign amt           = bus.imm[SHW-1:0];
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
    assign bus.result    = result_q;
    assign bus.ccr       = ccr_q;
    assign bus.out_valid = out_valid_q;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_product;

    assign is_mul = (bus.op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .abort   (bus.flush),
        .a       (bus.dst),
        .b       (bus.src),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_res        = mul_product[WIDTH-1:0];
    assign mul_ccr[CCR_Z] = (mul_product[WIDTH-1:0] == '0);
    assign mul_ccr[CCR_N] = mul_product[WIDTH-1];
    assign mul_ccr[CCR_C] = |mul_product[2*WIDTH-1:WIDTH];
    assign bus.busy       = (state == MUL_BUSY);
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_ccr  = '0;
    assign bus.busy = 1'b0;
`endif

    // Carry/borrow come from a WIDTH+1 bit result; shifts keep C when amt is zero
    always_comb begin
        res_c  = bus.dst;
        ccr_c  = ccr_q;
        wide   = '0;
        set_zn = 1'b0;
        case (bus.op)
            OP_ADD: begin
                wide          = {1'b0, bus.dst} + {1'b0, bus.src};
                res_c         = wide[WIDTH-1:0];
                ccr_c[CCR_C]  = wide[WIDTH];
                set_zn        = 1'b1;
            end
            OP_SUB: begin
                wide          = {1'b0, bus.dst} - {1'b0, bus.src};
                res_c         = wide[WIDTH-1:0];
                ccr_c[CCR_C]  = wide[WIDTH];
                set_zn        = 1'b1;
            end
            OP_AND: begin
                res_c  = bus.dst & bus.src;
                set_zn = 1'b1;
            end
            OP_OR: begin
                res_c  = bus.dst | bus.src;
                set_zn = 1'b1;
            end
            OP_NOT: begin
                res_c  = ~bus.dst;
                set_zn = 1'b1;
            end
            OP_INC: begin
                wide          = {1'b0, bus.dst} + (WIDTH+1)'(1);
                res_c         = wide[WIDTH-1:0];
                ccr_c[CCR_C]  = wide[WIDTH];
                set_zn        = 1'b1;
            end
            OP_DEC: begin
                wide          = {1'b0, bus.dst} - (WIDTH+1)'(1);
                res_c         = wide[WIDTH-1:0];
                ccr_c[CCR_C]  = wide[WIDTH];
                set_zn        = 1'b1;
            end
            OP_MOV: res_c = bus.src;
            OP_LDM: res_c = bus.imm;
            OP_SHL: begin
                wide   = {1'b0, bus.dst} << amt;
                res_c  = wide[WIDTH-1:0];
                if (amt != '0) begin
                    ccr_c[CCR_C] = wide[WIDTH];
                end
                set_zn = 1'b1;
            end
            OP_SHR: begin
                wide   = {bus.dst, 1'b0} >> amt;
                res_c  = wide[WIDTH:1];
                if (amt != '0) begin
                    ccr_c[CCR_C] = wide[0];
                end
                set_zn = 1'b1;
            end
            OP_SETC: ccr_c[CCR_C] = 1'b1;
            OP_CLRC: ccr_c[CCR_C] = 1'b0;
            default: ;
        endcase
        if (set_zn) begin
            ccr_c[CCR_Z] = (res_c == '0);
            ccr_c[CCR_N] = res_c[WIDTH-1];
        end
    end

    // ccr_load is applied last so it overrides any flag update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            result_q    <= '0;
            ccr_q       <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state <= MUL_BUSY;
                    end else if (accept) begin
                        result_q    <= res_c;
                        ccr_q       <= ccr_c;
                        out_valid_q <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (mul_done) begin
                        state       <= IDLE;
                        result_q    <= mul_res;
                        ccr_q       <= mul_ccr;
                        out_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (bus.ccr_load) begin
                ccr_q <= bus.ccr_in;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 16;
    localparam logic [31:0] MASK = 32'h0000_FFFF;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic         model_ok = 1'b0;
    logic [W-1:0] m_result;
    logic [2:0]   m_ccr;
    logic         m_ov;
    logic         m_busy;
    int           m_left;
    logic [W-1:0] m_pend_res;
    logic [2:0]   m_pend_ccr;
    logic [31:0]  m_r;
    logic [2:0]   m_nc;
    logic [31:0]  m_prod;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // flags are {C,N,Z}; plain integer arithmetic on 32-bit values
    function automatic void refOp(input int op, input logic [31:0] s, input logic [31:0] d,
                                  input logic [31:0] i, input logic [2:0] cin,
                                  output logic [31:0] res, output logic [2:0] cout);
        int   amt;
        logic c;
        bit   zn;
        amt = int'(i % W);
        c   = cin[2];
        zn  = 1'b1;
        res = d;
        case (op)
            1:  begin res = d + s; c = (res > MASK); end
            2:  begin c = (s > d); res = d - s; end
            3:  res = d & s;
            4:  res = d | s;
            5:  res = ~d;
            6:  begin res = d + 1; c = (res > MASK); end
            7:  begin c = (d == 0); res = d - 1; end
            8:  begin res = s; zn = 1'b0; end
            9:  begin res = i; zn = 1'b0; end
            10: begin res = d << amt; if (amt != 0) c = d[W - amt]; end
            11: begin res = d >> amt; if (amt != 0) c = d[amt - 1]; end
            12: begin c = 1'b1; zn = 1'b0; end
            13: begin c = 1'b0; zn = 1'b0; end
            default: zn = 1'b0;
        endcase
        res  = res & MASK;
        cout = cin;
        cout[2] = c;
        if (zn) begin
            cout[0] = (res == 0);
            cout[1] = res[W-1];
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1'b1;
            m_result = '0;
            m_ccr    = 3'b000;
            m_ov     = 1'b0;
            m_busy   = 1'b0;
            m_left   = 0;
        end else if (model_ok) begin
            m_ov = 1'b0;
            m_nc = m_ccr;
            if (m_busy) begin
                if (bus.flush) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy   = 1'b0;
                        m_result = m_pend_res;
                        m_nc     = m_pend_ccr;
                        m_ov     = 1'b1;
                    end
                end
            end else if (bus.in_valid && !bus.flush) begin
                if (MUL_EN && bus.op == OP_MUL) begin
                    m_prod     = 32'(bus.dst) * 32'(bus.src);
                    m_pend_res = m_prod[W-1:0];
                    m_pend_ccr = {m_prod[2*W-1:W] != 0, m_prod[W-1], m_prod[W-1:0] == 0};
                    m_busy     = 1'b1;
                    m_left     = W;
                end else begin
                    refOp(int'(bus.op), 32'(bus.src), 32'(bus.dst), 32'(bus.imm), m_ccr, m_r, m_nc);
                    m_result = m_r[W-1:0];
                    m_ov     = 1'b1;
                end
            end
            if (bus.ccr_load) m_nc = bus.ccr_in;
            m_ccr = m_nc;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("out_valid", 32'(bus.out_valid), 32'(m_ov));
            checkOutput("result", 32'(bus.result), 32'(m_result));
            checkOutput("ccr", 32'(bus.ccr), 32'(m_ccr));
            checkOutput("busy", 32'(bus.busy), 32'(m_busy));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(!m_busy && !rst));
        end
    end

    task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [W-1:0] s,
                                 input logic [W-1:0] d, input logic [W-1:0] i, input logic fl,
                                 input logic cl, input logic [2:0] ci);
        bus.in_valid = v;
        bus.op       = alu_op_e'(o);
        bus.src      = s;
        bus.dst      = d;
        bus.imm      = i;
        bus.flush    = fl;
        bus.ccr_load = cl;
        bus.ccr_in   = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 3'b000);
    endtask

    function automatic logic [W-1:0] pickVal();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    int ov_seen;

    initial begin
        rst = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("reset_result", 32'(bus.result), 32'h0);
        checkOutput("reset_ccr", 32'(bus.ccr), 32'h0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h0);
        rst = 1'b0;
        idleCycle();
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'h1);

        applyStimulus(1'b1, 4'd1, 16'h0001, 16'h7FFF, 16'h0, 1'b0, 1'b0, 3'b000);
        checkOutput("add_ovf_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("add_ovf_result", 32'(bus.result), 32'h8000);
        checkOutput("add_ovf_ccr", 32'(bus.ccr), 32'h2);
        checkOutput("model_add_result", 32'(m_result), 32'h8000);

        applyStimulus(1'b1, 4'd1, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 1'b0, 3'b000);
        checkOutput("add_carry_result", 32'(bus.result), 32'h0000);
        checkOutput("add_carry_ccr", 32'(bus.ccr), 32'h5);

        applyStimulus(1'b1, 4'd8, 16'h1234, 16'h0000, 16'h0, 1'b0, 1'b0, 3'b000);
        checkOutput("mov_result", 32'(bus.result), 32'h1234);
        checkOutput("mov_ccr", 32'(bus.ccr), 32'h5);

        applyStimulus(1'b1, 4'd2, 16'h0005, 16'h0003, 16'h0, 1'b0, 1'b0, 3'b000);
        checkOutput("sub_borrow_result", 32'(bus.result), 32'hFFFE);
        checkOutput("sub_borrow_ccr", 32'(bus.ccr), 32'h6);
        checkOutput("model_sub_ccr", 32'(m_ccr), 32'h6);

        applyStimulus(1'b1, 4'd10, 16'h0000, 16'h8001, 16'h0001, 1'b0, 1'b0, 3'b000);
        checkOutput("shl_result", 32'(bus.result), 32'h0002);
        checkOutput("shl_ccr", 32'(bus.ccr), 32'h4);

        applyStimulus(1'b1, 4'd1, 16'h0020, 16'h0010, 16'h0, 1'b0, 1'b1, 3'b101);
        checkOutput("ccr_load_result", 32'(bus.result), 32'h0030);
        checkOutput("ccr_load_ccr", 32'(bus.ccr), 32'h5);
        checkOutput("ccr_load_valid", 32'(bus.out_valid), 32'h1);

        applyStimulus(1'b1, 4'd1, 16'h1111, 16'h1111, 16'h0, 1'b1, 1'b0, 3'b000);
        checkOutput("flush_discard_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("flush_discard_result", 32'(bus.result), 32'h0030);

        applyStimulus(1'b1, 4'd13, 16'h0000, 16'h5555, 16'h0, 1'b0, 1'b0, 3'b000);
        checkOutput("clrc_ccr", 32'(bus.ccr), 32'h1);

`ifdef ALU_MUL_EN
        applyStimulus(1'b1, 4'd14, 16'h0100, 16'h0100, 16'h0, 1'b0, 1'b0, 3'b000);
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) idleCycle();
            checkOutput("mul_busy", 32'(bus.busy), 32'h1);
            checkOutput("mul_not_ready", 32'(bus.in_ready), 32'h0);
            checkOutput("mul_no_early_valid", 32'(bus.out_valid), 32'h0);
        end
        idleCycle();
        checkOutput("mul_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("mul_result", 32'(bus.result), 32'h0000);
        checkOutput("mul_ccr", 32'(bus.ccr), 32'h5);
        checkOutput("mul_done_busy", 32'(bus.busy), 32'h0);

        applyStimulus(1'b1, 4'd14, 16'h0005, 16'h0003, 16'h0, 1'b0, 1'b0, 3'b000);
        idleCycle();
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b0, 3'b000);
        checkOutput("mul_flush_ready", 32'(bus.in_ready), 32'h1);
        checkOutput("mul_flush_busy", 32'(bus.busy), 32'h0);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) ov_seen++;
            idleCycle();
        end
        checkOutput("mul_flush_no_valid", 32'(ov_seen), 32'h0);
        checkOutput("mul_flush_result", 32'(bus.result), 32'h0000);
        checkOutput("mul_flush_ccr", 32'(bus.ccr), 32'h5);
`else
        applyStimulus(1'b1, 4'd14, 16'h0003, 16'hABCD, 16'h0, 1'b0, 1'b0, 3'b000);
        checkOutput("op14_nop_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("op14_nop_result", 32'(bus.result), 32'hABCD);
        checkOutput("op14_nop_ccr", 32'(bus.ccr), 32'h1);
        checkOutput("op14_nop_busy", 32'(bus.busy), 32'h0);
`endif

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), pickVal(), pickVal(),
                          W'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                          3'($urandom_range(0, 7)));
        end
        rst = 1'b0;
        for (int n = 0; n < 20; n++) idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
